serial_adder_sub: RTL and testbench
===================================

Name: serial_adder_sub

Overview:
- Parametrised bit-serial adder/subtractor; successor to the single-bit full adder.
- Reuses one full-adder cell per clock with a carry flip-flop. Processes WIDTH-bit operands LSB-first over WIDTH cycles.
- Provides a start/done handshake, add/subtract mode, carry-out and signed-overflow flags.
- Sits as a small-area arithmetic unit next to the combinational adder library.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32. With WIDTH=1 the block is a registered full adder.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low: sampled on the rising clk edge, no asynchronous path.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract (a - b); latched with start.
- cin  input  1  carry-in for add mode; latched with start; ignored when sub=1.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result register.
- cout  output  1  final carry out; in sub mode 1 = no borrow.
- ovf  output  1  signed (two's-complement) overflow.

Behaviour:
- Reset: on any edge with rst_n=0, the following are cleared.
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal shift registers, bit counter and carry FF cleared.
  - Reset mid-RUN aborts the operation: no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1.
    - Latch a into shift register A.
    - Latch b into shift register B; use ~b if sub=1.
    - Carry FF loads cin (add mode) or 1 (sub mode).
    - Counter=0.
  - RUN: one bit per cycle.
    - s = A[0]^B[0]^c.
    - c_next = majority(A[0], B[0], c).
    - Shift s into the MSB of the result shift register; shift A and B right.
    - Counter++.
    - When counter == WIDTH-1 (the final bit is processed this cycle), go to DONE.
  - DONE, one cycle:
    - done=1.
    - sum/cout/ovf updated on entry to DONE.
    - ovf = carry into MSB XOR carry out of MSB, using the carry FF value captured before the last bit.
    - Next state is IDLE unconditionally.
- Latency: start sampled at edge N; busy=1 from edge N through N+WIDTH; done=1 in the cycle after edge N+WIDTH, i.e. WIDTH+1 cycles after start was sampled.
- sum, cout and ovf hold the previous result during RUN and after done until the next DONE. They never show partial values.
- start while busy or in DONE: ignored, no queuing. Operand or sub changes during RUN have no effect.
- start held high continuously: a new operation starts at each return to IDLE. Throughput is one result per WIDTH+2 cycles.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- Counter width is clog2(WIDTH)+1. WIDTH=1 is handled: RUN lasts exactly one cycle.

Test Plan:
- WIDTH=8, add, a=0x64, b=0x9B, cin=1 -> done 9 cycles after start; sum=0x00, cout=1, ovf=0; busy high for exactly 8 cycles.
- WIDTH=8, add, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Then sub, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- WIDTH=8, sub, a=0x05, b=0x07, cin=1 (ignored) -> sum=0xFE, cout=0 (borrow), ovf=0. sum holds 0xFE until the next done.
- WIDTH=8, start re-pulsed and operands changed mid-RUN -> result equals the first operands only; exactly one done pulse.
- WIDTH=8, rst_n=0 for one cycle at RUN bit 3 -> all outputs 0 next cycle, no done. A fresh start afterwards computes correctly.
- WIDTH=1, all 8 combinations of a, b, cin in add mode -> sum/cout match the full-adder truth table (e.g. 1,1,1 -> sum=1, cout=1), with done 2 cycles after start.

Source files
------------

// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one full-adder cell reused LSB-first
// over WIDTH cycles, with start/done handshake and carry/overflow flags.
module serial_adder_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_c;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_a_nxt;

  assign w_s = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

  // Result bits enter A's MSB as operand bits leave its LSB
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_a_nxt = w_s;
    end else begin : g_wn
      assign w_a_nxt = {w_s, r_a[WIDTH-1:1]};
    end
  endgenerate

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_c     <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        (r_state == S_RUN): begin
          r_a   <= w_a_nxt;
          r_b   <= r_b >> 1;
          r_c   <= w_c;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            sum     <= w_a_nxt;
            cout    <= w_c;
            // r_c is still the carry into the MSB here
            ovf     <= r_c ^ w_c;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_sub.sv
// Scoreboard bench for serial_adder_sub at WIDTH=8 and WIDTH=1.
// Drivers push expected results; negedge monitors pop on done.
module tb_serial_adder_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       start1, sub1, cin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  always #5 clk = ~clk;

  serial_adder_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .cin(cin8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .ovf(ovf8)
  );

  serial_adder_sub #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .cin(cin1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1),
    .cout(cout1), .ovf(ovf1)
  );

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         at;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bc8 = 0;
  int   bc1 = 0;
  logic [7:0] last8 = '0;
  logic       last1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("w8_rst_busy", 32'(busy8), 0);
      chk("w8_rst_done", 32'(done8), 0);
      chk("w8_rst_sum",  32'(sum8),  0);
      chk("w8_rst_cout", 32'(cout8), 0);
      chk("w8_rst_ovf",  32'(ovf8),  0);
      last8 = '0;
      bc8   = 0;
    end else begin
      if (busy8) begin
        bc8++;
        chk("w8_sum_hold", 32'(sum8), 32'(last8));
      end
      if (done8) begin
        if (q8.size() == 0) begin
          chk("w8_spurious_done", 1, 0);
        end else begin
          e = q8.pop_front();
          chk("w8_sum",  32'(sum8),  32'(e.s));
          chk("w8_cout", 32'(cout8), 32'(e.c));
          chk("w8_ovf",  32'(ovf8),  32'(e.o));
          chk("w8_latency", cyc, e.at);
          chk("w8_busy_cycles", bc8, 8);
          last8 = e.s;
        end
        bc8 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("w1_rst_busy", 32'(busy1), 0);
      chk("w1_rst_done", 32'(done1), 0);
      chk("w1_rst_sum",  32'(sum1),  0);
      last1 = 1'b0;
      bc1   = 0;
    end else begin
      if (busy1) begin
        bc1++;
        chk("w1_sum_hold", 32'(sum1), 32'(last1));
      end
      if (done1) begin
        if (q1.size() == 0) begin
          chk("w1_spurious_done", 1, 0);
        end else begin
          e = q1.pop_front();
          chk("w1_sum",  32'(sum1),  32'(e.s[0]));
          chk("w1_cout", 32'(cout1), 32'(e.c));
          chk("w1_ovf",  32'(ovf1),  32'(e.o));
          chk("w1_latency", cyc, e.at);
          chk("w1_busy_cycles", bc1, 1);
          last1 = e.s[0];
        end
        bc1 = 0;
      end
    end
  end

  task automatic go8(input logic s, input logic c,
                     input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] es, input logic ec,
                     input logic eo);
    exp_t e;
    @(negedge clk);
    sub8 = s; cin8 = c; a8 = x; b8 = y; start8 = 1'b1;
    e.s = es; e.c = ec; e.o = eo; e.at = cyc + 9;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic go1(input logic x, input logic y, input logic c,
                     input logic es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    sub1 = 1'b0; cin1 = c; a1 = x; b1 = y; start1 = 1'b1;
    e.s = {7'b0, es}; e.c = ec; e.o = eo; e.at = cyc + 2;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // {a, b, cin, sum, cout, ovf}
  logic [5:0] tv1 [8] = '{
    6'b000_000, 6'b001_101, 6'b010_100, 6'b011_010,
    6'b100_100, 6'b101_010, 6'b110_011, 6'b111_110
  };

  initial begin
    exp_t e;
    rst_n = 1'b0;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
    start1 = 0; sub1 = 0; cin1 = 0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    go8(1'b0, 1'b1, 8'h64, 8'h9B, 8'h00, 1'b1, 1'b0);
    go8(1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    go8(1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    go8(1'b1, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);

    // re-pulsed start and operand changes while running
    @(negedge clk);
    sub8 = 0; cin8 = 0; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    e.s = 8'h46; e.c = 1'b0; e.o = 1'b0; e.at = cyc + 9;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (10) @(negedge clk);

    // reset at RUN bit 3 aborts without a done pulse
    @(negedge clk);
    sub8 = 0; cin8 = 0; a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);

    go8(1'b0, 1'b0, 8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0);
    go8(1'b1, 1'b0, 8'h3C, 8'h3C, 8'h00, 1'b1, 1'b0);

    // start held high: back-to-back ops every WIDTH+2 cycles
    @(negedge clk);
    sub8 = 0; cin8 = 0; a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
    e.s = 8'h03; e.c = 1'b0; e.o = 1'b0; e.at = cyc + 9;
    q8.push_back(e);
    e.at = cyc + 19;
    q8.push_back(e);
    repeat (11) @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      logic [5:0] v;
      v = tv1[i];
      go1(v[5], v[4], v[3], v[2], v[1], v[0]);
    end

    repeat (5) @(negedge clk);
    chk("w8_missing_done", q8.size(), 0);
    chk("w1_missing_done", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
